// File: rtl/vend_controller.sv
// Purpose: vending transaction sequencer that tracks coin credit, looks up item stock and price, dispenses the item and pays out change.
// Latency: a selection accepted with enough credit gives LOOKUP, then EVAL, then dispense_pulse 3 cycles later and change_valid 4 cycles later.
// Backpressure: cfg/sel/coin ready flags are state decodes; config wins over a selection in IDLE, and coins are dropped outside IDLE/COLLECT.
module vend_controller #(
    parameter int NUM_ITEMS      = 1024,
    parameter int ADDR_W         = $clog2(NUM_ITEMS),
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [7:0]        cfg_dispensed,
    input  logic [7:0]        cfg_count,
    input  logic [15:0]       cfg_price,
    output logic              cfg_ready,
    input  logic              sel_valid,
    input  logic [ADDR_W-1:0] sel_item,
    output logic              sel_ready,
    input  logic              coin_valid,
    input  logic [15:0]       coin_value,
    output logic              coin_ready,
    input  logic              cancel,
    output logic              mem_we,
    output logic              mem_dispense_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_dispensed,
    output logic [7:0]        mem_count,
    output logic [15:0]       mem_price,
    input  logic [31:0]       mem_rdata,
    output logic              dispense_pulse,
    output logic [ADDR_W-1:0] dispense_item,
    output logic              change_valid,
    output logic [15:0]       change_amount,
    output logic              err_sold_out,
    output logic              err_bad_item,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_EVAL,
        S_COLLECT,
        S_VEND,
        S_CHANGE
    } state_t;

    state_t            state;
    logic [15:0]       balance;
    logic [ADDR_W-1:0] item;
    logic [15:0]       price_r;
    logic [31:0]       tmo_cnt;

    logic              coin_acc;
    logic              sel_acc;
    logic              sel_bad;
    logic [16:0]       coin_sum;
    logic [15:0]       bal_plus;
    logic [7:0]        rd_count;
    logic [15:0]       rd_price;
    logic              tmo_last;
    logic              unused_rdata;

    // The dispensed byte of the read word is never needed by the sequencer.
    assign unused_rdata = ^mem_rdata[31:24];

    // Port decodes: config and selections only in IDLE, coins in IDLE and COLLECT.
    assign cfg_ready          = (state == S_IDLE);
    assign sel_ready          = (state == S_IDLE) && !cfg_we;
    assign coin_ready         = (state == S_IDLE) || (state == S_COLLECT);
    assign mem_we             = (state == S_IDLE) && cfg_we;
    assign mem_dispense_valid = (state == S_VEND);
    assign mem_addr           = (state == S_IDLE) ? cfg_addr : item;
    assign mem_dispensed      = cfg_dispensed;
    assign mem_count          = cfg_count;
    assign mem_price          = cfg_price;
    assign dispense_pulse     = (state == S_VEND);
    assign dispense_item      = item;
    assign change_valid       = (state == S_CHANGE);
    assign change_amount      = (state == S_CHANGE) ? balance : 16'd0;
    assign busy               = (state != S_IDLE);

    // Credit after any accepted coin (saturating), selection checks and read-data fields.
    always_comb begin
        coin_acc = coin_valid && coin_ready;
        sel_acc  = sel_valid && sel_ready;
        sel_bad  = (32'(sel_item) >= 32'(NUM_ITEMS));
        coin_sum = {1'b0, balance} + {1'b0, coin_value};
        bal_plus = balance;
        if (coin_acc) begin
            bal_plus = coin_sum[16] ? 16'hFFFF : coin_sum[15:0];
        end
        rd_count = mem_rdata[23:16];
        rd_price = mem_rdata[15:0];
        tmo_last = (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
    end

    // Transaction FSM with balance, latched item/price, timeout counter and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            balance      <= 16'd0;
            item         <= '0;
            price_r      <= 16'd0;
            tmo_cnt      <= 32'd0;
            err_sold_out <= 1'b0;
            err_bad_item <= 1'b0;
        end else begin
            err_sold_out <= 1'b0;
            err_bad_item <= 1'b0;
            case (state)
                S_IDLE: begin
                    balance <= bal_plus;
                    if (sel_acc) begin
                        if (sel_bad) begin
                            err_bad_item <= 1'b1;
                        end else begin
                            item  <= sel_item;
                            state <= S_LOOKUP;
                        end
                    end else if (cancel && (balance != 16'd0)) begin
                        state <= S_CHANGE;
                    end
                end
                S_LOOKUP: begin
                    state <= S_EVAL;
                end
                S_EVAL: begin
                    price_r <= rd_price;
                    if (rd_count == 8'd0) begin
                        err_sold_out <= 1'b1;
                        state        <= (balance != 16'd0) ? S_CHANGE : S_IDLE;
                    end else if (balance >= rd_price) begin
                        state <= S_VEND;
                    end else begin
                        tmo_cnt <= 32'd0;
                        state   <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    balance <= bal_plus;
                    tmo_cnt <= coin_acc ? 32'd0 : tmo_cnt + 32'd1;
                    if (cancel) begin
                        state <= S_CHANGE;
                    end else if (balance >= price_r) begin
                        state <= S_VEND;
                    end else if (!coin_acc && tmo_last) begin
                        state <= (balance != 16'd0) ? S_CHANGE : S_IDLE;
                    end
                end
                S_VEND: begin
                    balance <= (balance >= price_r) ? (balance - price_r) : 16'd0;
                    state   <= (balance > price_r) ? S_CHANGE : S_IDLE;
                end
                S_CHANGE: begin
                    balance <= 16'd0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: decode vector table, directed corner sequences, then random purchases against a transaction-level model.
// Small configuration (12 items, 4-bit address, 16-cycle timeout) so out-of-range selections and the timeout are reachable.
// The item memory is modelled here with a registered read port and a dispense update.
module tb_vend_controller;

    localparam int NI  = 12;
    localparam int AW  = 4;
    localparam int TMO = 16;

    logic          clk;
    logic          rst;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [7:0]    cfg_dispensed;
    logic [7:0]    cfg_count;
    logic [15:0]   cfg_price;
    logic          cfg_ready;
    logic          sel_valid;
    logic [AW-1:0] sel_item;
    logic          sel_ready;
    logic          coin_valid;
    logic [15:0]   coin_value;
    logic          coin_ready;
    logic          cancel;
    logic          mem_we;
    logic          mem_dispense_valid;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_dispensed;
    logic [7:0]    mem_count;
    logic [15:0]   mem_price;
    logic [31:0]   mem_rdata;
    logic          dispense_pulse;
    logic [AW-1:0] dispense_item;
    logic          change_valid;
    logic [15:0]   change_amount;
    logic          err_sold_out;
    logic          err_bad_item;
    logic          busy;

    vend_controller #(.NUM_ITEMS(NI), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_dispensed(cfg_dispensed),
        .cfg_count(cfg_count), .cfg_price(cfg_price), .cfg_ready(cfg_ready),
        .sel_valid(sel_valid), .sel_item(sel_item), .sel_ready(sel_ready),
        .coin_valid(coin_valid), .coin_value(coin_value), .coin_ready(coin_ready),
        .cancel(cancel),
        .mem_we(mem_we), .mem_dispense_valid(mem_dispense_valid), .mem_addr(mem_addr),
        .mem_dispensed(mem_dispensed), .mem_count(mem_count), .mem_price(mem_price),
        .mem_rdata(mem_rdata),
        .dispense_pulse(dispense_pulse), .dispense_item(dispense_item),
        .change_valid(change_valid), .change_amount(change_amount),
        .err_sold_out(err_sold_out), .err_bad_item(err_bad_item), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Item memory: config write, dispense update, registered read.
    logic [31:0] tb_mem [0:15];
    logic [31:0] ref_mem [0:15];
    always @(posedge clk) begin
        if (mem_we) begin
            tb_mem[mem_addr] <= {mem_dispensed, mem_count, mem_price};
        end else if (mem_dispense_valid) begin
            tb_mem[mem_addr] <= {tb_mem[mem_addr][31:24] + 8'd1,
                                 tb_mem[mem_addr][23:16] - 8'd1,
                                 tb_mem[mem_addr][15:0]};
        end
        mem_rdata <= tb_mem[mem_addr];
    end

    int n_chk;
    int n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    typedef struct {
        logic          cfg_we;
        logic          sel_valid;
        logic [AW-1:0] sel_item;
        logic [AW-1:0] cfg_addr;
        logic          exp_mem_we;
        logic          exp_sel_ready;
        logic          exp_bad;
    } vec_t;

    vec_t vecs [6];

    // Model state for the random phase.
    logic [15:0]   credit;
    logic [15:0]   price;
    logic [15:0]   v;
    logic [15:0]   e_chg;
    logic [15:0]   g_chg;
    logic [AW-1:0] it;
    logic [AW-1:0] g_item;
    logic          need_coins;
    logic          e_bad;
    logic          e_sold;
    int            n_disp, n_chg, n_sold, n_bad, idle_run, k;

    initial begin
        n_chk = 0;
        n_fail = 0;
        for (int i = 0; i < 16; i++) begin
            tb_mem[i]  = 32'd0;
            ref_mem[i] = 32'd0;
        end
        rst = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_dispensed = 8'd0; cfg_count = 8'd0; cfg_price = 16'd0;
        sel_valid = 1'b0; sel_item = '0; coin_valid = 1'b0; coin_value = 16'd0; cancel = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 4'd0,  4'd3,  1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 4'd0,  4'd9,  1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 4'd2,  4'd10, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 4'd12, 4'd4,  1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 4'd15, 4'd0,  1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 4'd13, 4'd6,  1'b1, 1'b0, 1'b0};

        repeat (3) cyc();
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_change_valid", change_valid, 1'b0);
        chk("rst_change_amount", change_amount, 16'd0);
        chk("rst_dispense", dispense_pulse, 1'b0);
        chk("rst_errs", {err_sold_out, err_bad_item}, 2'b00);
        chk("rst_cfg_ready", cfg_ready, 1'b1);

        // IDLE decode table; no vector starts a real purchase.
        for (int i = 0; i < 6; i++) begin
            cfg_we = vecs[i].cfg_we; sel_valid = vecs[i].sel_valid;
            sel_item = vecs[i].sel_item; cfg_addr = vecs[i].cfg_addr;
            #1;
            chk("vec_mem_we", mem_we, vecs[i].exp_mem_we);
            chk("vec_sel_ready", sel_ready, vecs[i].exp_sel_ready);
            chk("vec_mem_addr", mem_addr, vecs[i].cfg_addr);
            chk("vec_coin_ready", coin_ready, 1'b1);
            cyc();
            chk("vec_err_bad", err_bad_item, vecs[i].exp_bad);
            chk("vec_busy", busy, 1'b0);
        end
        cfg_we = 1'b0; sel_valid = 1'b0; cfg_addr = '0;

        // A: credit 200, config item 5 collides with a selection, then purchase with change.
        coin_valid = 1'b1; coin_value = 16'd100; cyc();
        coin_value = 16'd100; cyc();
        coin_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = 4'd5; cfg_dispensed = 8'd0; cfg_count = 8'd3; cfg_price = 16'd150;
        sel_valid = 1'b1; sel_item = 4'd5;
        #1;
        chk("A_cfg_mem_we", mem_we, 1'b1);
        chk("A_cfg_sel_ready", sel_ready, 1'b0);
        cyc();
        cfg_we = 1'b0; cfg_addr = 4'd0;
        #1;
        chk("A_sel_ready", sel_ready, 1'b1);
        cyc();
        sel_valid = 1'b0;
        chk("A_lookup_addr", mem_addr, 4'd5);
        chk("A_lookup_busy", busy, 1'b1);
        cyc();
        chk("A_eval_no_disp", dispense_pulse, 1'b0);
        cyc();
        chk("A_disp", {dispense_pulse, mem_dispense_valid, mem_we}, 3'b110);
        chk("A_disp_item", dispense_item, 4'd5);
        cyc();
        chk("A_change_valid", change_valid, 1'b1);
        chk("A_change_amount", change_amount, 16'd50);
        cyc();
        chk("A_idle", {busy, change_valid}, 2'b00);
        chk("A_mem_word", tb_mem[5], 32'h01020096);

        // B: zero credit, collect coins to exactly the price, no change.
        sel_valid = 1'b1; sel_item = 4'd5; cyc();
        sel_valid = 1'b0;
        cyc();
        chk("B_eval_coin_ready", coin_ready, 1'b0);
        cyc();
        chk("B_collect", {busy, coin_ready}, 2'b11);
        coin_valid = 1'b1; coin_value = 16'd100; cyc();
        coin_value = 16'd25; cyc();
        coin_value = 16'd25; cyc();
        coin_valid = 1'b0;
        chk("B_pre_vend", dispense_pulse, 1'b0);
        cyc();
        chk("B_vend", dispense_pulse, 1'b1);
        chk("B_vend_no_change", change_valid, 1'b0);
        cyc();
        chk("B_after", {busy, change_valid}, 2'b00);
        chk("B_mem_word", tb_mem[5], 32'h02010096);

        // C: sold-out item 7 with credit 40.
        cfg_we = 1'b1; cfg_addr = 4'd7; cfg_dispensed = 8'd0; cfg_count = 8'd0; cfg_price = 16'd99;
        coin_valid = 1'b1; coin_value = 16'd40;
        cyc();
        cfg_we = 1'b0; coin_valid = 1'b0; sel_valid = 1'b1; sel_item = 4'd7;
        cyc();
        sel_valid = 1'b0;
        cyc();
        chk("C_eval_no_dv", mem_dispense_valid, 1'b0);
        cyc();
        chk("C_sold_out", err_sold_out, 1'b1);
        chk("C_change", {change_valid, mem_dispense_valid}, 2'b10);
        chk("C_change_amount", change_amount, 16'd40);
        cyc();
        chk("C_after", {busy, err_sold_out}, 2'b00);

        // D: timeout with credit 60 in COLLECT.
        coin_valid = 1'b1; coin_value = 16'd60; cyc();
        coin_valid = 1'b0; sel_valid = 1'b1; sel_item = 4'd5; cyc();
        sel_valid = 1'b0;
        cyc();
        for (int i = 0; i < TMO; i++) begin
            cyc();
            chk("D_wait", {busy, change_valid}, 2'b10);
        end
        cyc();
        chk("D_tmo_change", change_valid, 1'b1);
        chk("D_tmo_amount", change_amount, 16'd60);
        cyc();
        chk("D_after", busy, 1'b0);

        // E: coin and cancel together in COLLECT with prior credit 30.
        coin_valid = 1'b1; coin_value = 16'd30; cyc();
        coin_valid = 1'b0; sel_valid = 1'b1; sel_item = 4'd5; cyc();
        sel_valid = 1'b0;
        cyc();
        cyc();
        coin_valid = 1'b1; coin_value = 16'd20; cancel = 1'b1;
        cyc();
        coin_valid = 1'b0; cancel = 1'b0;
        chk("E_change", change_valid, 1'b1);
        chk("E_amount", change_amount, 16'd50);
        cyc();
        chk("E_after", busy, 1'b0);

        // F: reset in COLLECT drops credit without strobes.
        coin_valid = 1'b1; coin_value = 16'd70; cyc();
        coin_valid = 1'b0; sel_valid = 1'b1; sel_item = 4'd5; cyc();
        sel_valid = 1'b0;
        cyc();
        cyc();
        chk("F_in_collect", busy, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("F_rst_state", {busy, change_valid, dispense_pulse, err_sold_out, err_bad_item}, 5'b0);
        chk("F_rst_amount", change_amount, 16'd0);
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        chk("F_cancel_empty", {busy, change_valid}, 2'b00);

        // G: cancel in IDLE refunds credit.
        coin_valid = 1'b1; coin_value = 16'd33; cyc();
        coin_valid = 1'b0; cancel = 1'b1; cyc();
        cancel = 1'b0;
        chk("G_change", change_valid, 1'b1);
        chk("G_amount", change_amount, 16'd33);
        cyc();

        // H: credit saturates at 0xFFFF.
        coin_valid = 1'b1; coin_value = 16'hFFF0; cyc();
        coin_value = 16'h0100; cyc();
        coin_valid = 1'b0; cancel = 1'b1; cyc();
        cancel = 1'b0;
        chk("H_sat_amount", change_amount, 16'hFFFF);
        cyc();

        // Random phase: load every valid slot, then random purchases.
        for (int i = 0; i < NI; i++) begin
            cfg_we = 1'b1; cfg_addr = AW'(i);
            cfg_dispensed = 8'($urandom_range(0, 5));
            cfg_count = 8'($urandom_range(0, 2));
            cfg_price = 16'($urandom_range(1, 250));
            ref_mem[i] = {cfg_dispensed, cfg_count, cfg_price};
            cyc();
        end
        cfg_we = 1'b0;
        credit = 16'd0;

        for (int t = 0; t < 40; t++) begin
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) begin
                v = 16'($urandom_range(1, 200));
                coin_valid = 1'b1; coin_value = v;
                credit = sat_add(credit, v);
                cyc();
            end
            coin_valid = 1'b0;
            it = AW'($urandom_range(0, 14));
            sel_valid = 1'b1; sel_item = it;
            cyc();
            sel_valid = 1'b0;

            e_bad = 1'b0; e_sold = 1'b0; e_chg = 16'd0; need_coins = 1'b0; price = 16'd0;
            if (int'(it) >= NI) begin
                e_bad = 1'b1;
            end else if (ref_mem[it][23:16] == 8'd0) begin
                e_sold = 1'b1;
                e_chg = credit;
                credit = 16'd0;
            end else begin
                price = ref_mem[it][15:0];
                need_coins = 1'b1;
            end

            n_disp = 0; n_chg = 0; n_sold = 0; n_bad = 0; idle_run = 0;
            g_item = '0; g_chg = 16'd0;
            for (int c = 0; c < 80 && idle_run < 2; c++) begin
                if (dispense_pulse) begin n_disp++; g_item = dispense_item; end
                if (change_valid) begin n_chg++; g_chg = change_amount; end
                if (err_sold_out) n_sold++;
                if (err_bad_item) n_bad++;
                idle_run = busy ? 0 : idle_run + 1;
                coin_valid = 1'b0;
                if (need_coins && busy && coin_ready && credit < price) begin
                    v = 16'($urandom_range(1, 200));
                    coin_valid = 1'b1; coin_value = v;
                    credit = sat_add(credit, v);
                end
                cyc();
            end
            coin_valid = 1'b0;
            chk("rnd_done", (idle_run >= 2), 1'b1);

            if (need_coins) begin
                e_chg = credit - price;
                credit = 16'd0;
                ref_mem[it] = {ref_mem[it][31:24] + 8'd1, ref_mem[it][23:16] - 8'd1, ref_mem[it][15:0]};
            end
            chk("rnd_n_disp", n_disp, need_coins ? 1 : 0);
            if (need_coins) chk("rnd_disp_item", g_item, it);
            chk("rnd_n_change", n_chg, (e_chg != 16'd0) ? 1 : 0);
            if (e_chg != 16'd0) chk("rnd_change_amt", g_chg, e_chg);
            chk("rnd_sold", n_sold, e_sold ? 1 : 0);
            chk("rnd_bad", n_bad, e_bad ? 1 : 0);
            if (!e_bad) chk("rnd_mem", tb_mem[it], ref_mem[it]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Transaction sequencer for the per-item stock/price memory: `{dispensed[31:24], count[23:16], price[15:0]}` per item, one registered read port, one write/dispense port.
- Arbitrates the memory port between operator configuration writes and customer purchases.
- Accumulates coin credit, looks up stock and price, issues the dispense update, and returns change.
- Sits between the coin/keypad front end and the item memory.

Parameters:
- NUM_ITEMS, 1024, number of valid item slots; selections at or above this are rejected.
- ADDR_W, $clog2(NUM_ITEMS), item address width.
- TIMEOUT_CYCLES, 1000000, idle cycles in COLLECT before auto-refund; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  operator config write request
- cfg_addr  in  ADDR_W  config item address
- cfg_dispensed  in  8  config dispensed-count value
- cfg_count  in  8  config stock value
- cfg_price  in  16  config price
- cfg_ready  out  1  config write is accepted this cycle
- sel_valid  in  1  customer item selection request
- sel_item  in  ADDR_W  selected item index
- sel_ready  out  1  selection is accepted this cycle
- coin_valid  in  1  one coin inserted this cycle
- coin_value  in  16  value of the coin
- coin_ready  out  1  coins are accepted this cycle
- cancel  in  1  customer cancel/refund request
- mem_we  out  1  to memory write enable
- mem_dispense_valid  out  1  to memory dispense update
- mem_addr  out  ADDR_W  to memory common address
- mem_dispensed, mem_count  out  8 each  to memory write data
- mem_price  out  16  to memory write data
- mem_rdata  in  32  from memory registered read data
- dispense_pulse  out  1  item released
- dispense_item  out  ADDR_W  item being released
- change_valid  out  1  change payout strobe
- change_amount  out  16  change value
- err_sold_out  out  1  one-cycle pulse: selected item has zero stock
- err_bad_item  out  1  one-cycle pulse: sel_item >= NUM_ITEMS
- busy  out  1  state != IDLE

Behaviour:
- Reset:
  - state=IDLE; balance=0; item register=0; timeout counter=0.
  - All strobes and err_* are 0; change_amount=0.
  - A reset mid-transaction discards the balance. No change and no dispense are issued.
- States: IDLE, LOOKUP, EVAL, COLLECT, VEND, CHANGE.
- Outputs:
  - mem_*, cfg_ready, sel_ready, coin_ready, dispense_*, change_*, busy are combinational decodes of the state and registers.
  - err_* are registered.
- mem_addr = cfg_addr in IDLE; otherwise it is the latched item.
- mem_dispensed/count/price = cfg_* inputs.
- IDLE:
  - cfg_ready=1; mem_we=cfg_we, passed through in the same cycle.
  - sel_ready = ~cfg_we, so config wins a simultaneous request. The selection stays pending.
  - Accepted sel with sel_item >= NUM_ITEMS: err_bad_item=1 next cycle; stay IDLE.
  - Otherwise latch sel_item and go to LOOKUP.
  - cancel with balance>0 and no accepted sel -> CHANGE. cancel with balance=0 is ignored.
  - Accepted sel has priority over cancel.
- Coins:
  - coin_ready=1 in IDLE and COLLECT only; coins in any other state are dropped.
  - balance <= balance + coin_value, saturating at 16'hFFFF.
  - A coin and a selection in the same IDLE cycle are both accepted.
- LOOKUP (1 cycle): mem_addr=item; memory registers read data at the end of the cycle.
- EVAL (1 cycle): count=mem_rdata[23:16], price=mem_rdata[15:0].
  - count==0: err_sold_out pulse; go to CHANGE if balance>0, else IDLE.
  - balance >= price: go to VEND.
  - Otherwise go to COLLECT and clear the timeout counter.
- COLLECT:
  - Each cycle, compare the registered balance against the price latched in EVAL. If balance >= price, go to VEND.
  - cancel: go to CHANGE. A coin in the same cycle is added first, so the refund includes it.
  - The timeout counter clears on every coin and increments otherwise. At TIMEOUT_CYCLES-1, go to CHANGE, or to IDLE if balance=0.
  - Cancel takes priority over the price check.
- VEND (1 cycle):
  - mem_dispense_valid=1, mem_we=0, dispense_pulse=1, dispense_item=item.
  - balance <= balance - price, never negative.
  - Next state is CHANGE if the remainder > 0, else IDLE.
- CHANGE (1 cycle): change_valid=1, change_amount=balance; balance <= 0; go to IDLE.
- Latency: selection accepted at edge E0 with sufficient credit -> LOOKUP in cycle 1, EVAL in cycle 2, dispense_pulse in cycle 3, change_valid in cycle 4.
- Config writes are impossible outside IDLE, so there is no stock race with the dispense update.
- The price comparison is unsigned 16-bit.

Test Plan:
- Config write addr 5 = {0, 3, 150} with sel_valid high in the same cycle -> mem_we=1 that cycle, sel_ready=0; selection accepted the next cycle.
- Coins 100+100, then select item 5 -> dispense_pulse in cycle 3 with dispense_item=5; change_valid with change_amount=50 in cycle 4; memory word becomes {1, 2, 150}.
- Select item 5 with balance 0 -> COLLECT; coins 100, 25, 25 -> VEND one cycle after the balance reaches 150; no change_valid.
- Item 7 with count 0, balance 40 -> err_sold_out pulse; change_amount=40; no mem_dispense_valid.
- sel_item=NUM_ITEMS -> err_bad_item pulse, busy stays 0. Then COLLECT with balance 60 and no coins for TIMEOUT_CYCLES -> change_amount=60.
- In COLLECT, coin 20 and cancel in the same cycle with prior balance 30 -> change_amount=50. rst asserted in COLLECT -> IDLE, balance 0, no strobes.
